alu_scheduler: RTL and testbench
================================

# alu_scheduler

Two-requester arbiter and sequencer for the 4-bit gray-input ALU core.
- Accepts binary operand/op requests from two clients over valid/ready.
- Picks one client per operation by round-robin, converts the operands to gray code and drives the ALU core.
- Holds the operands stable for a programmable settle window, since the core is combinational with multi-stage propagation delay.
- Captures R/Zero/Overflow into a buffered, tagged response and keeps a saturating overflow count.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles operands are held on the ALU before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a, req0_b  in  4 each  requester 0 operands, plain binary.
- req0_op  in  2  requester 0 ALU op, passed through unmodified.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_g1, alu_g2  out  4 each  gray-coded operands to the ALU core.
- alu_op  out  2  op to the ALU core.
- alu_r  in  4  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_ovf  in  1  ALU overflow flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index the response belongs to.
- rsp_r  out  4  captured result.
- rsp_zero, rsp_ovf  out  1 each  captured flags.
- busy  out  1  high in any state other than IDLE.
- ovf_count  out  8  saturating count of completed ops with rsp_ovf=1.

## Operation
- FSM states are IDLE, SETTLE and RESP.
- IDLE:
  - The grant goes to the single valid requester.
  - If both are valid, the grant goes to the requester not granted last. last_grant resets to 1, so req0 wins the first tie.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational, and at most one ready is high.
  - On handshake:
    - Register alu_g1 = a ^ (a>>1), alu_g2 = b ^ (b>>1), alu_op = op, id = N.
    - Set last_grant = N.
    - Load settle counter = SETTLE_CYCLES-1.
    - Go to SETTLE.
- SETTLE:
  - If the counter is nonzero, decrement it.
  - If the counter is 0:
    - Capture alu_r, alu_zero and alu_ovf into rsp_r, rsp_zero, rsp_ovf.
    - Set rsp_valid=1 and go to RESP.
    - If alu_ovf=1 and ovf_count<255, increment ovf_count. At 255 it holds.
- RESP:
  - rsp_* is held constant while rsp_valid=1.
  - When rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- alu_g1, alu_g2 and alu_op change only on a request handshake. They hold their last value through RESP and IDLE, so the core never sees spurious transitions.
- No request is accepted while in SETTLE or RESP. Both ready outputs stay low there.
- Requesters must hold reqN_* stable while valid and not ready. A valid requester that is not granted is never dropped. After losing a tie it wins the next arbitration.
- Reset, including reset asserted in SETTLE or RESP:
  - State goes to IDLE.
  - In-flight op is discarded with no response.
  - All outputs go to 0: ready, alu_*, rsp_*, busy, ovf_count.
  - last_grant goes to 1.

## Timing
- Handshake at edge E0. ALU inputs are valid after E0.
- Capture happens at edge E0+SETTLE_CYCLES. rsp_valid is high in the following cycle.
- Accept-to-rsp_valid latency is exactly SETTLE_CYCLES cycles.
- A response accepted at edge E1 gives IDLE in the next cycle, and the earliest next handshake is at edge E1+1.
- Minimum issue interval with rsp_ready held high is SETTLE_CYCLES+2 cycles.
- rsp_ready low stalls indefinitely in RESP, with rsp_* stable and no new accepts.
- busy = (state != IDLE), registered with the state.

## Test plan
- Reset, then req0 only, a=5, b=3, op=00, SETTLE_CYCLES=4, bench ALU model returning r=8, ovf=1:
  - req0_ready is high in the request cycle.
  - alu_g1=0111 and alu_g2=0010.
  - rsp_valid rises 4 cycles after the handshake with rsp_id=0, rsp_r=8, rsp_ovf=1.
  - ovf_count=1.
- Both requesters valid continuously for 4 ops with rsp_ready=1:
  - Grant order is 0,1,0,1.
  - rsp_id sequence is 0,1,0,1.
  - Handshakes are spaced exactly 6 cycles apart.
- rsp_ready held low for 10 cycles in RESP:
  - rsp_valid and rsp_r are stable throughout.
  - Both ready outputs are 0 and busy=1.
  - Raising rsp_ready completes the response, and the next handshake occurs one cycle later.
- rst pulsed for one cycle during SETTLE:
  - No response is produced.
  - All outputs are 0 in the following cycle, and ovf_count=0.
  - A simultaneous req0/req1 afterwards grants req0.
- 260 ops with ALU model ovf=1:
  - ovf_count reaches 255 and stays at 255.
- a=15, b=8 with SETTLE_CYCLES=1:
  - alu_g1=1000 and alu_g2=1100.
  - rsp_valid rises 1 cycle after the handshake.
  - The ALU model changing alu_r after capture does not change rsp_r.

Source files
------------

// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Round-robin arbiter/sequencer in front of the 4-bit gray-input ALU core.
//   Two requesters hand over binary operands on valid/ready. The winner's
//   operands are gray-coded and held on the core for SETTLE_CYCLES cycles.
//   The core outputs are then captured into a tagged response that is held
//   until the consumer accepts it.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req{0,1}_valid/ready   request handshake per client
//   req{0,1}_a/_b/_op      binary operands and op
//   alu_g1/_g2/_op         gray operands and op driven to the core
//   alu_r/_zero/_ovf       core result and flags
//   rsp_valid/ready        response handshake
//   rsp_id/_r/_zero/_ovf   response tag, result and flags
//   busy                   FSM not in IDLE
//   ovf_count              saturating count of overflowing completions
module alu_scheduler #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic [3:0] alu_g1,
  output logic [3:0] alu_g2,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_r,
  output logic       rsp_zero,
  output logic       rsp_ovf,
  output logic       busy,
  output logic [7:0] ovf_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } req_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       id_q;
  logic [3:0] cnt;
  logic       hs;
  logic       cap;
  req_t       sel;

  function automatic logic [3:0] gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  // Tie goes to the client not served last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign hs         = req0_ready || req1_ready;
  assign cap        = (state == SETTLE) && (cnt == 4'd0);
  assign sel        = grant ? req_t'{req1_a, req1_b, req1_op}
                            : req_t'{req0_a, req0_b, req0_op};
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs)                     state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0)            state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      cnt        <= 4'd0;
      alu_g1     <= 4'd0;
      alu_g2     <= 4'd0;
      alu_op     <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_r      <= 4'd0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      ovf_count  <= 8'd0;
    end else begin
      state <= state_nxt;
      // Core inputs move only here, so the core never sees glitches
      // between operations.
      if (hs) begin
        alu_g1     <= gray(sel.a);
        alu_g2     <= gray(sel.b);
        alu_op     <= sel.op;
        id_q       <= grant;
        last_grant <= grant;
        cnt        <= 4'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_r     <= alu_r;
        rsp_zero  <= alu_zero;
        rsp_ovf   <= alu_ovf;
        if (alu_ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end else if (state == RESP && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with SETTLE_CYCLES=4
  logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_ovf, busy;
  logic [3:0] alu_g1, alu_g2, alu_r, rsp_r;
  logic [1:0] alu_op;
  logic       alu_zero, alu_ovf;
  logic [7:0] ovf_count;
  logic [3:0] model_r = 0;
  logic       model_ovf = 0;
  assign alu_r    = model_r;
  assign alu_zero = (model_r == 4'd0);
  assign alu_ovf  = model_ovf;

  // Instance with SETTLE_CYCLES=1
  logic       d_req0_valid = 0, d_req1_valid = 0, d_rsp_ready = 0;
  logic [3:0] d_req0_a = 0, d_req0_b = 0, d_req1_a = 0, d_req1_b = 0;
  logic [1:0] d_req0_op = 0, d_req1_op = 0;
  logic       d_req0_ready, d_req1_ready, d_rsp_valid, d_rsp_id, d_rsp_zero, d_rsp_ovf, d_busy;
  logic [3:0] d_alu_g1, d_alu_g2, d_alu_r, d_rsp_r;
  logic [1:0] d_alu_op;
  logic       d_alu_zero, d_alu_ovf;
  logic [7:0] d_ovf_count;
  logic [3:0] d_model_r = 0;
  assign d_alu_r    = d_model_r;
  assign d_alu_zero = (d_model_r == 4'd0);
  assign d_alu_ovf  = 1'b0;

  alu_scheduler #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_g1(alu_g1), .alu_g2(alu_g2), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .busy(busy), .ovf_count(ovf_count)
  );

  alu_scheduler #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(d_req0_valid), .req0_ready(d_req0_ready), .req0_a(d_req0_a), .req0_b(d_req0_b), .req0_op(d_req0_op),
    .req1_valid(d_req1_valid), .req1_ready(d_req1_ready), .req1_a(d_req1_a), .req1_b(d_req1_b), .req1_op(d_req1_op),
    .alu_g1(d_alu_g1), .alu_g2(d_alu_g2), .alu_op(d_alu_op),
    .alu_r(d_alu_r), .alu_zero(d_alu_zero), .alu_ovf(d_alu_ovf),
    .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_id(d_rsp_id), .rsp_r(d_rsp_r),
    .rsp_zero(d_rsp_zero), .rsp_ovf(d_rsp_ovf), .busy(d_busy), .ovf_count(d_ovf_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too,
  // well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until rsp_valid is seen; returns cycles taken, or -1 on timeout.
  task automatic wait_rsp(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (rsp_valid) begin n = i; break; end
    end
  endtask

  int n;
  int hs_n, rs_n, rsp_seen, stable_ok, done;
  int hs_cyc [4];
  logic hs_id [4];
  logic rs_id [4];

  initial begin
    // ---- reset state ----
    rst = 1; step(); step(); rst = 0; #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_g1", alu_g1, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf_count", ovf_count, 0);

    // ---- single req0: a=5 b=3, model r=8 ovf=1 ----
    model_r = 4'd8; model_ovf = 1;
    req0_a = 4'd5; req0_b = 4'd3; req0_op = 2'b00; req0_valid = 1; #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    step(); req0_valid = 0; #1;
    chk("t1_g1", alu_g1, 4'b0111);
    chk("t1_g2", alu_g2, 4'b0010);
    chk("t1_op", alu_op, 2'b00);
    chk("t1_busy", busy, 1);
    wait_rsp(10, n);
    chk("t1_latency", n, 4);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_r", rsp_r, 8);
    chk("t1_rsp_ovf", rsp_ovf, 1);
    chk("t1_rsp_zero", rsp_zero, 0);
    chk("t1_ovf_count", ovf_count, 1);
    rsp_ready = 1; step(); rsp_ready = 0; #1;
    chk("t1_idle", busy, 0);

    // ---- round-robin with both valid (reset first so last_grant=1) ----
    rst = 1; step(); rst = 0;
    model_ovf = 0; model_r = 4'd3;
    req0_a = 4'd1; req0_b = 4'd2; req0_op = 2'b01;
    req1_a = 4'd3; req1_b = 4'd4; req1_op = 2'b11;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1; #1;
    hs_n = 0; rs_n = 0;
    for (int c = 0; c < 80 && (hs_n < 4 || rs_n < 4); c++) begin
      if (hs_n == 4) begin req0_valid = 0; req1_valid = 0; #1; end
      if (hs_n < 4 && req0_ready) begin hs_id[hs_n] = 0; hs_cyc[hs_n] = c; hs_n++; end
      else if (hs_n < 4 && req1_ready) begin hs_id[hs_n] = 1; hs_cyc[hs_n] = c; hs_n++; end
      if (rsp_valid && rs_n < 4) begin rs_id[rs_n] = rsp_id; rs_n++; end
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    chk("rr_hs_count", hs_n, 4);
    chk("rr_rsp_count", rs_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), hs_id[i], i % 2);
      chk($sformatf("rr_rsp_id%0d", i), rs_id[i], i % 2);
    end
    for (int i = 0; i < 3; i++) chk($sformatf("rr_space%0d", i), hs_cyc[i+1] - hs_cyc[i], 6);
    step(); #1;

    // ---- stall in RESP (last grant was 1) ----
    model_r = 4'hA; model_ovf = 1;
    req0_a = 4'd6; req0_b = 4'd9; req0_op = 2'b11; req0_valid = 1; #1;
    chk("st_ready0", req0_ready, 1);
    step(); req0_valid = 0;
    req1_a = 4'd12; req1_b = 4'd7; req1_op = 2'b10; req1_valid = 1; #1;
    chk("st_op", alu_op, 2'b11);
    chk("st_ready1_settle", req1_ready, 0);
    wait_rsp(10, n);
    chk("st_latency", n, 4);
    model_r = 4'h5;  // core changing after capture must not show up
    stable_ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (!(rsp_valid === 1 && rsp_r === 4'hA && req0_ready === 0 && req1_ready === 0 && busy === 1))
        stable_ok = 0;
      step();
    end
    chk("st_stable", stable_ok, 1);
    chk("st_ovf_count", ovf_count, 1);
    rsp_ready = 1; step(); rsp_ready = 0; #1;
    chk("st_rsp_cleared", rsp_valid, 0);
    chk("st_next_ready1", req1_ready, 1);
    step(); req1_valid = 0; #1;
    chk("st_next_busy", busy, 1);
    chk("st_next_g1", alu_g1, 4'b1010);

    // ---- reset during SETTLE ----
    step();
    rst = 1; step(); rst = 0; #1;
    chk("rs_busy", busy, 0);
    chk("rs_g1", alu_g1, 0);
    chk("rs_g2", alu_g2, 0);
    chk("rs_op", alu_op, 0);
    chk("rs_rsp_valid", rsp_valid, 0);
    chk("rs_rsp_r", rsp_r, 0);
    chk("rs_ovf_count", ovf_count, 0);
    rsp_seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (rsp_valid) rsp_seen = 1; end
    chk("rs_no_rsp", rsp_seen, 0);
    req0_valid = 1; req1_valid = 1; #1;
    chk("rs_tie_ready0", req0_ready, 1);
    chk("rs_tie_ready1", req1_ready, 0);
    req1_valid = 0;
    step(); req0_valid = 0;
    wait_rsp(10, n);
    rsp_ready = 1; step(); rsp_ready = 0;

    // ---- ovf_count saturation over 260 ops ----
    rst = 1; step(); rst = 0;
    model_ovf = 1; model_r = 4'd1;
    req0_valid = 1; rsp_ready = 1; #1;
    done = 0;
    for (int c = 0; c < 3000 && done < 260; c++) begin
      if (rsp_valid) begin
        done++;
        if (done == 254) chk("sat_254", ovf_count, 254);
        if (done == 255) chk("sat_255", ovf_count, 255);
      end
      step();
    end
    req0_valid = 0;
    step(); step(); #1;
    chk("sat_done", done, 260);
    chk("sat_hold", ovf_count, 255);
    rsp_ready = 0;

    // ---- SETTLE_CYCLES=1, a=15 b=8 ----
    d_model_r = 4'd3;
    d_req0_a = 4'd15; d_req0_b = 4'd8; d_req0_op = 2'b01; d_req0_valid = 1; #1;
    chk("s1_ready0", d_req0_ready, 1);
    step(); d_req0_valid = 0; #1;
    chk("s1_g1", d_alu_g1, 4'b1000);
    chk("s1_g2", d_alu_g2, 4'b1100);
    chk("s1_valid_early", d_rsp_valid, 0);
    step();
    chk("s1_valid", d_rsp_valid, 1);
    chk("s1_rsp_r", d_rsp_r, 3);
    d_model_r = 4'd9;
    step(); step();
    chk("s1_rsp_r_hold", d_rsp_r, 3);
    d_rsp_ready = 1; step(); d_rsp_ready = 0; #1;
    chk("s1_idle", d_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
